// File: rtl/match_sequencer.sv
// match_sequencer
// Match-level controller for the Pong video pipeline (25 MHz pixel clock).
// Sequences IDLE -> SERVE -> PLAY -> POINT/GAME_OVER, gates ball motion,
// commands ball re-centering, keeps both score digits and declares the winner.
// All waits are counted in frame pulses from the VGA timing block.
//
// Ports:
//   clock_25M   in   pixel clock, the only clock
//   reset_n     in   synchronous active-low reset
//   frame       in   one-cycle pulse at start of vertical blanking
//   start       in   debounced start button (level, rising edge acts)
//   miss_left   in   ball passed left edge: right player scores
//   miss_right  in   ball passed right edge: left player scores
//   ball_enable out  high only in PLAY, freezes ball motion when low
//   ball_center out  one-cycle pulse on SERVE entry: load ball at centre
//   serve_dir   out  direction to load with ball_center, 1 = rightward
//   score_left  out  left score digit, 0..WIN_SCORE
//   score_right out  right score digit, 0..WIN_SCORE
//   winner      out  00 none, 01 left, 10 right
//   state       out  current state (IDLE 0, SERVE 1, PLAY 2, POINT 3, GAME_OVER 4)
module match_sequencer #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clock_25M,
  input  logic       reset_n,
  input  logic       frame,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_enable,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [8:0] SERVE_CNT = 9'(SERVE_FRAMES);
  localparam logic [8:0] POINT_CNT = 9'(POINT_FRAMES);
  localparam logic [3:0] WIN_CNT   = 4'(WIN_SCORE);

  state_t     state_reg, state_next;
  logic [8:0] cnt_reg, cnt_next;
  logic       start_q_reg;
  logic       ball_enable_reg, ball_enable_next;
  logic       ball_center_reg, ball_center_next;
  logic       serve_dir_reg, serve_dir_next;
  logic [3:0] score_left_reg, score_left_next;
  logic [3:0] score_right_reg, score_right_next;
  logic [1:0] winner_reg, winner_next;

  logic       start_rise;
  logic [3:0] score_left_inc;
  logic [3:0] score_right_inc;

  // start_q resets high so a button held through reset is not seen as an edge.
  assign start_rise      = start & ~start_q_reg;
  assign score_left_inc  = score_left_reg + 4'd1;
  assign score_right_inc = score_right_reg + 4'd1;

  always_ff @(posedge clock_25M) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= 9'd0;
      start_q_reg     <= 1'b1;
      ball_enable_reg <= 1'b0;
      ball_center_reg <= 1'b0;
      serve_dir_reg   <= 1'b1;
      score_left_reg  <= 4'd0;
      score_right_reg <= 4'd0;
      winner_reg      <= 2'b00;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      start_q_reg     <= start;
      ball_enable_reg <= ball_enable_next;
      ball_center_reg <= ball_center_next;
      serve_dir_reg   <= serve_dir_next;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
      winner_reg      <= winner_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    ball_center_next = 1'b0;
    serve_dir_next   = serve_dir_reg;
    score_left_next  = score_left_reg;
    score_right_next = score_right_reg;
    winner_next      = winner_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start_rise) begin
          state_next       = ST_SERVE;
          cnt_next         = SERVE_CNT;
          ball_center_next = 1'b1;
          serve_dir_next   = 1'b1;
          score_left_next  = 4'd0;
          score_right_next = 4'd0;
        end
      end

      ST_SERVE: begin
        if (frame) begin
          cnt_next = cnt_reg - 9'd1;
          if (cnt_reg == 9'd1) begin
            state_next = ST_PLAY;
          end
        end
      end

      ST_PLAY: begin
        // miss_left has priority when both edges are missed in one cycle.
        if (miss_left) begin
          score_right_next = score_right_inc;
          serve_dir_next   = 1'b0;
          if (score_right_inc == WIN_CNT) begin
            state_next  = ST_GAME_OVER;
            winner_next = 2'b10;
          end else begin
            state_next = ST_POINT;
            cnt_next   = POINT_CNT;
          end
        end else if (miss_right) begin
          score_left_next = score_left_inc;
          serve_dir_next  = 1'b1;
          if (score_left_inc == WIN_CNT) begin
            state_next  = ST_GAME_OVER;
            winner_next = 2'b01;
          end else begin
            state_next = ST_POINT;
            cnt_next   = POINT_CNT;
          end
        end
      end

      ST_POINT: begin
        if (frame) begin
          if (cnt_reg == 9'd1) begin
            state_next       = ST_SERVE;
            cnt_next         = SERVE_CNT;
            ball_center_next = 1'b1;
          end else begin
            cnt_next = cnt_reg - 9'd1;
          end
        end
      end

      ST_GAME_OVER: begin
        // Re-serve keeps serve_dir so the player who lost serves first.
        if (start_rise) begin
          state_next       = ST_SERVE;
          cnt_next         = SERVE_CNT;
          ball_center_next = 1'b1;
          score_left_next  = 4'd0;
          score_right_next = 4'd0;
          winner_next      = 2'b00;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Registered copy of the PLAY decode so it tracks state exactly.
    ball_enable_next = (state_next == ST_PLAY);
  end

  assign ball_enable = ball_enable_reg;
  assign ball_center = ball_center_reg;
  assign serve_dir   = serve_dir_reg;
  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;
  assign winner      = winner_reg;
  assign state       = state_reg;

endmodule

// File: doc/match_sequencer.md
# match_sequencer

Match-level controller for the Pong video pipeline, in the 25 MHz pixel clock domain. Sequences attract, serve countdown, rally, point pause and game-over phases. Gates ball motion in the pixel datapath through `ball_enable` and commands ball re-centering. Owns both score digits and declares the winner; all timing is counted in `frame` pulses from the VGA timing block.

## Interface
- `SERVE_FRAMES`, 60: number of frame pulses the ball sits centred before a serve; range 1..511.
- `POINT_FRAMES`, 90: number of frame pulses of pause after a point; range 1..511.
- `WIN_SCORE`, 9: score that ends the match; range 1..9, so the score fits one decimal digit.
- `clock_25M` in 1: pixel clock; the only clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `frame` in 1: one-cycle pulse at the start of vertical blanking.
- `start` in 1: debounced start button, level; the block acts only on its rising edge.
- `miss_left` in 1: ball passed the left edge, so the right player scores; level.
- `miss_right` in 1: ball passed the right edge, so the left player scores; level.
- `ball_enable` out 1: high only in PLAY; while low the datapath freezes ball motion.
- `ball_center` out 1: one-cycle pulse; the datapath loads the ball at (320,240).
- `serve_dir` out 1: ball horizontal direction to load with `ball_center`; 1 = rightward.
- `score_left` out 4: left score, 0..WIN_SCORE.
- `score_right` out 4: right score, 0..WIN_SCORE.
- `winner` out 2: 00 = none, 01 = left, 10 = right; 11 is never driven.
- `state` out 3: current state, for debug and overlay. Encoding: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, GAME_OVER = 4.

## Operation
- Start edge detect:
  - `start_q` register; reset value 1, so a button held through reset does not trigger.
  - `start_rise = start & ~start_q`.
- Frame counter: 9 bits, `cnt`. It is loaded on every entry to SERVE or POINT and decrements on each `frame` pulse while in SERVE or POINT.
- IDLE (state after reset):
  - Scores 0, `winner` 00, `ball_enable` 0.
  - On `start_rise`:
    - go to SERVE;
    - clear scores;
    - set `serve_dir` = 1;
    - pulse `ball_center`;
    - set `cnt` = SERVE_FRAMES.
- SERVE:
  - `ball_enable` 0.
  - A `frame` pulse with `cnt` == 1 moves the state to PLAY.
  - The ball therefore waits exactly SERVE_FRAMES frame pulses.
- PLAY:
  - `ball_enable` 1.
  - `miss_left`:
    - `score_right` += 1;
    - `serve_dir` = 0 (serve toward the player who conceded).
  - `miss_right`:
    - `score_left` += 1;
    - `serve_dir` = 1.
  - If `miss_left` and `miss_right` are high in the same cycle, only `miss_left` is honoured.
  - After any scoring event:
    - if the new score == WIN_SCORE, go to GAME_OVER and set `winner`;
    - otherwise go to POINT with `cnt` = POINT_FRAMES.
  - One event scores at most one point. The state leaves PLAY on the next edge, so a miss level held for several cycles scores once.
- POINT:
  - `ball_enable` 0.
  - A `frame` pulse with `cnt` == 1 moves the state to SERVE, pulses `ball_center`, and sets `cnt` = SERVE_FRAMES.
- GAME_OVER:
  - `ball_enable` 0; scores and `winner` are held.
  - On `start_rise`:
    - go to SERVE;
    - clear scores and `winner`;
    - pulse `ball_center`;
    - set `cnt` = SERVE_FRAMES;
    - keep `serve_dir` unchanged (the loser serves).
- Ignored inputs:
  - `start_rise` is ignored in SERVE, PLAY and POINT.
  - `miss_*` are ignored outside PLAY.
  - `frame` is ignored in IDLE, PLAY and GAME_OVER.
- Scores never exceed WIN_SCORE and never wrap. Score arithmetic is 4-bit unsigned.

## Timing
- All outputs are registered and change one cycle after the qualifying input cycle.
- `ball_center` is high for exactly the first cycle in which `state` == SERVE. It is never high in any other cycle.
- `ball_enable` == (`state` == PLAY), with the same timing as `state`.
- A `frame` pulse in the same cycle as the SERVE/POINT entry event is not counted.
- Reset values: `state` 0, `ball_enable` 0, `ball_center` 0, `serve_dir` 1, scores 0, `winner` 00, `cnt` 0, `start_q` 1.
- Reset asserted mid-match, in any state, returns every register to its reset value on the next edge. Reset overrides every other input.

## Test plan
- Reset, then a `start` rising edge → next cycle:
  - `state` = 1, `ball_center` = 1 for one cycle, `serve_dir` = 1, scores 0.
  - After exactly 60 `frame` pulses, `state` = 2 and `ball_enable` = 1.
- In PLAY, pulse `miss_right` for 3 cycles → `score_left` = 1, `serve_dir` = 1, `state` = 3. After 90 frames: `state` = 1 with a single `ball_center` pulse.
- In PLAY, assert `miss_left` and `miss_right` in the same cycle → `score_right` += 1, `score_left` unchanged, `serve_dir` = 0.
- Drive the left score to 8, then `miss_right` → `score_left` = 9, `winner` = 01, `state` = 4, `ball_enable` = 0. A further `miss_right` → no change. `start` edge → scores 0, `winner` 00, `state` = 1, `serve_dir` = 1.
- Hold `start` high through reset release → `state` stays 0 until `start` falls and rises again. Assert `reset_n` = 0 mid-POINT → all outputs at their reset values on the next edge.
